irq_generator: RTL and testbench
================================

Name: irq_generator

Overview:
- Downstream of the video unit: converts its `mid_screen` and `vblank` line strobes into 8080-style interrupt requests.
- mid-screen → RST 1 (opcode 0xCF); vblank → RST 2 (opcode 0xD7).
- Presents a latched vector to the CPU core with a req/ack handshake, holds pending interrupts while the CPU has interrupts disabled, and counts lost events.

Parameters:
- ACK_GAP, 2: idle cycles after an acknowledge before another request may be raised (lets the CPU drop `int_enable`).
- HOLD_PENDING, 1: 1 = events arriving while `int_enable`=0 stay pending; 0 = such events are discarded.
- MID_VECTOR, 8'hCF: opcode presented for a mid-screen interrupt.
- VBL_VECTOR, 8'hD7: opcode presented for a vblank interrupt.

Ports:
- clk  input  1  system clock (same domain as video unit)
- rst_n  input  1  synchronous, active-low reset
- mid_screen  input  1  from video unit; high for one full scanline at the mid-screen line
- vblank  input  1  from video unit; high for one full scanline at start of vertical back porch
- int_enable  input  1  CPU interrupt-enable flag (INTE)
- int_ack  input  1  one-cycle CPU acknowledge; valid only while `int_req`=1
- int_req  output  1  interrupt request to CPU
- int_vector  output  8  RST opcode for the CPU to execute
- overrun_count  output  8  saturating count of events lost to an already-pending same source
- clr_overrun  input  1  synchronous clear of `overrun_count`

Behaviour:
- **Reset (`rst_n`=0 at posedge):**
  - State IDLE; both pending bits 0; edge-detect history 0.
  - `int_req`=0, `int_vector`=8'h00, `overrun_count`=0, holdoff counter 0.
- **Edge detection:**
  - Per source, `rise = in & ~prev`; `prev` is registered every cycle.
  - A level held for 800 cycles yields exactly one event.
- **Pending bits (`pend_mid`, `pend_vbl`):**
  - Set on rise.
  - If HOLD_PENDING=0 and `int_enable`=0 in the rise cycle, the rise is ignored entirely (no set, no overrun).
- **Overrun:**
  - A rise on a source whose pending bit is already 1, and that is not being cleared by an ack in the same cycle, increments `overrun_count`.
  - Saturates at 255 (no wrap).
  - Two sources overrunning in the same cycle add 2, still saturating.
  - `clr_overrun` zeroes the count; if an overrun occurs in the same cycle, the result is 1 (clear then add).
- **FSM states: IDLE, REQ, HOLDOFF.**
  - **IDLE:**
    - `int_req`=0, `int_vector`=8'h00.
    - If `int_enable`=1 and any pending bit is set: latch `sel` (vblank has priority over mid if both are pending) and go to REQ.
  - **REQ:**
    - `int_req`=1; `int_vector` = the vector of the latched `sel`, stable for the whole state.
    - On `int_ack`=1: clear `pend[sel]`, load the holdoff counter with ACK_GAP, go to HOLDOFF.
    - Else if `int_enable`=0: withdraw, returning to IDLE with pending bits unchanged.
    - `int_ack` takes precedence over `int_enable`=0 in the same cycle.
  - **HOLDOFF:**
    - `int_req`=0, `int_vector`=8'h00.
    - The counter decrements each cycle; on reaching 0, go to IDLE.
    - ACK_GAP=0 means HOLDOFF lasts exactly 1 cycle.
- **Simultaneous events:**
  - Ack and a new rise on the same source in one cycle: the set wins, the bit stays 1, and no overrun is counted.
  - A rise on the other source during REQ only sets its pending bit; `sel` does not change mid-request.
- **Spurious ack:** `int_ack` outside REQ is ignored.
- **Latency:** input first sampled high at posedge k (pending set at k) → `int_req`=1 after posedge k+1, provided the FSM was in IDLE and `int_enable`=1.
- **Reset mid-operation:** returns immediately to reset values; pending and overrun state is lost.

Test Plan:
- **Basic mid-screen:** `int_enable`=1, pulse `mid_screen` high 800 cycles → `int_req`=1 two edges after the rise, `int_vector`=8'hCF; ack → `int_req`=0, vector 8'h00; no second request during the remaining high cycles.
- **Priority:** `int_enable`=0, raise `vblank` then `mid_screen`; then set `int_enable`=1 → first request 8'hD7; ack; after ACK_GAP=2 holdoff, second request 8'hCF.
- **Disabled behaviour:**
  - HOLD_PENDING=1: three `mid_screen` events with `int_enable`=0 → one pending, `overrun_count`=2.
  - HOLD_PENDING=0, same stimulus → nothing pending, `overrun_count`=0.
- **Withdraw:** in REQ with vector 8'hD7, drop `int_enable` with no ack → `int_req`=0 next cycle; re-enable → request 8'hD7 again.
- **Same-cycle events:** `int_ack` in the same cycle as a new `mid_screen` rise while `sel`=mid → pending stays 1, count unchanged, new 8'hCF request after holdoff. Also force 300 overruns → count holds at 255; `clr_overrun` → 0.
- **Reset during REQ:** assert `rst_n`=0 for 1 cycle → `int_req`=0, `int_vector`=8'h00, `overrun_count`=0, no request until the next input rise.

Source files
------------

// File: rtl/irq_generator.sv
// Turns the video unit's mid-screen and vblank line strobes into 8080 RST interrupt
// requests with a req/ack handshake, pending-hold while INTE is low, and an overrun counter.
module irq_generator #(
    parameter int unsigned ACK_GAP      = 2,
    parameter bit          HOLD_PENDING = 1'b1,
    parameter logic [7:0]  MID_VECTOR   = 8'hCF,
    parameter logic [7:0]  VBL_VECTOR   = 8'hD7
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       mid_screen,
    input  logic       vblank,
    input  logic       int_enable,
    input  logic       int_ack,
    input  logic       clr_overrun,
    output logic       int_req,
    output logic [7:0] int_vector,
    output logic [7:0] overrun_count
);

    typedef enum logic [1:0] {IDLE, REQ, HOLDOFF} state_e;

    state_e     state_q;
    logic       sel_vbl_q;
    logic [7:0] holdoff_q;
    logic       int_req_q;
    logic [7:0] int_vector_q;

    logic       prev_mid_q, prev_vbl_q;
    logic       pend_mid_q, pend_vbl_q;
    logic       pend_mid_d, pend_vbl_d;
    logic [7:0] overrun_q, overrun_d;

    logic       accept;
    logic       set_mid, set_vbl;
    logic       ack_fire, clr_mid, clr_vbl;
    logic       ovr_mid, ovr_vbl;
    logic [7:0] ovr_base;
    logic [8:0] ovr_sum;

    // With HOLD_PENDING=0, an event seen while interrupts are disabled never happened.
    assign accept   = HOLD_PENDING | int_enable;
    assign set_mid  = mid_screen & ~prev_mid_q & accept;
    assign set_vbl  = vblank & ~prev_vbl_q & accept;

    // Acks only count while a request is actually being presented.
    assign ack_fire = (state_q == REQ) & int_ack;
    assign clr_mid  = ack_fire & ~sel_vbl_q;
    assign clr_vbl  = ack_fire & sel_vbl_q;

    assign ovr_mid  = set_mid & pend_mid_q & ~clr_mid;
    assign ovr_vbl  = set_vbl & pend_vbl_q & ~clr_vbl;

    always_comb begin
        pend_mid_d = set_mid | (pend_mid_q & ~clr_mid);
        pend_vbl_d = set_vbl | (pend_vbl_q & ~clr_vbl);
        // Clear first, then add this cycle's overruns, saturating at 255.
        ovr_base   = clr_overrun ? 8'd0 : overrun_q;
        ovr_sum    = {1'b0, ovr_base} + {8'd0, ovr_mid} + {8'd0, ovr_vbl};
        overrun_d  = ovr_sum[8] ? 8'hFF : ovr_sum[7:0];
    end

    // NOTE: every register below is updated with <= so all of them see the same
    // pre-edge values; a blocking = here would leak new state into later reads.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            prev_mid_q <= 1'b0;
            prev_vbl_q <= 1'b0;
            pend_mid_q <= 1'b0;
            pend_vbl_q <= 1'b0;
            overrun_q  <= 8'd0;
        end else begin
            prev_mid_q <= mid_screen;
            prev_vbl_q <= vblank;
            pend_mid_q <= pend_mid_d;
            pend_vbl_q <= pend_vbl_d;
            overrun_q  <= overrun_d;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q      <= IDLE;
            sel_vbl_q    <= 1'b0;
            holdoff_q    <= 8'd0;
            int_req_q    <= 1'b0;
            int_vector_q <= 8'h00;
        end else begin
            case (state_q)
                IDLE: begin
                    if (int_enable && (pend_mid_q || pend_vbl_q)) begin
                        sel_vbl_q    <= pend_vbl_q;
                        int_req_q    <= 1'b1;
                        int_vector_q <= pend_vbl_q ? VBL_VECTOR : MID_VECTOR;
                        state_q      <= REQ;
                    end
                end
                REQ: begin
                    if (int_ack) begin
                        holdoff_q    <= 8'(ACK_GAP);
                        int_req_q    <= 1'b0;
                        int_vector_q <= 8'h00;
                        state_q      <= HOLDOFF;
                    end else if (!int_enable) begin
                        int_req_q    <= 1'b0;
                        int_vector_q <= 8'h00;
                        state_q      <= IDLE;
                    end
                end
                HOLDOFF: begin
                    // Leaving on the cycle the count would reach zero keeps ACK_GAP=0 at one cycle.
                    if (holdoff_q <= 8'd1) begin
                        holdoff_q <= 8'd0;
                        state_q   <= IDLE;
                    end else begin
                        holdoff_q <= holdoff_q - 8'd1;
                    end
                end
                default: begin
                    int_req_q    <= 1'b0;
                    int_vector_q <= 8'h00;
                    state_q      <= IDLE;
                end
            endcase
        end
    end

    assign int_req       = int_req_q;
    assign int_vector    = int_vector_q;
    assign overrun_count = overrun_q;

endmodule

// File: tb/tb_irq_generator.sv
// Directed bench for irq_generator: a cycle-by-cycle vector table plus hand sequences
// for long pulses, overrun saturation, HOLD_PENDING=0 and reset during a request.
module tb_irq_generator;

    logic       clk;
    logic       rst_n, mid_screen, vblank, int_enable, int_ack, clr_overrun;
    logic       int_req, np_req;
    logic [7:0] int_vector, np_vector;
    logic [7:0] overrun_count, np_overrun;

    int total = 0;
    int bad   = 0;

    irq_generator dut (
        .clk(clk), .rst_n(rst_n), .mid_screen(mid_screen), .vblank(vblank),
        .int_enable(int_enable), .int_ack(int_ack), .clr_overrun(clr_overrun),
        .int_req(int_req), .int_vector(int_vector), .overrun_count(overrun_count)
    );

    irq_generator #(.HOLD_PENDING(1'b0)) dut_np (
        .clk(clk), .rst_n(rst_n), .mid_screen(mid_screen), .vblank(vblank),
        .int_enable(int_enable), .int_ack(int_ack), .clr_overrun(clr_overrun),
        .int_req(np_req), .int_vector(np_vector), .overrun_count(np_overrun)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic       rst_n, mid, vbl, en, ack, clr;
        logic       req;
        logic [7:0] vec, ovr;
    } vec_t;

    vec_t tbl[$];

    task automatic add(input logic r, m, v, e, a, c, input logic q,
                       input logic [7:0] vc, input logic [7:0] ov);
        vec_t t;
        t.rst_n = r; t.mid = m; t.vbl = v; t.en = e; t.ack = a; t.clr = c;
        t.req = q; t.vec = vc; t.ovr = ov;
        tbl.push_back(t);
    endtask

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Drive inputs away from the edge, then sample 1 time unit after the posedge.
    task automatic drive(input logic r, m, v, e, a, c);
        @(negedge clk);
        rst_n = r; mid_screen = m; vblank = v; int_enable = e; int_ack = a; clr_overrun = c;
        @(posedge clk);
        #1;
    endtask

    int req_seen;

    initial begin
        rst_n = 1'b0; mid_screen = 1'b0; vblank = 1'b0;
        int_enable = 1'b0; int_ack = 1'b0; clr_overrun = 1'b0;

        //   rst mid vbl en ack clr | req vec    ovr
        add(0, 0, 0, 0, 0, 0,  0, 8'h00, 8'd0);  // 0 reset
        add(1, 0, 0, 1, 0, 0,  0, 8'h00, 8'd0);
        add(1, 1, 0, 1, 0, 0,  0, 8'h00, 8'd0);  // mid rise -> pending
        add(1, 1, 0, 1, 0, 0,  1, 8'hCF, 8'd0);  // request one edge later
        add(1, 1, 0, 1, 1, 0,  0, 8'h00, 8'd0);  // ack -> holdoff
        add(1, 1, 0, 1, 0, 0,  0, 8'h00, 8'd0);
        add(1, 1, 0, 1, 0, 0,  0, 8'h00, 8'd0);
        add(1, 1, 0, 1, 0, 0,  0, 8'h00, 8'd0);  // held level: no new event
        add(1, 0, 0, 1, 0, 0,  0, 8'h00, 8'd0);
        add(1, 0, 1, 0, 0, 0,  0, 8'h00, 8'd0);  // 9 vbl while disabled
        add(1, 1, 0, 0, 0, 0,  0, 8'h00, 8'd0);  // mid while disabled
        add(1, 0, 0, 0, 1, 0,  0, 8'h00, 8'd0);  // spurious ack in IDLE
        add(1, 0, 0, 1, 0, 0,  1, 8'hD7, 8'd0);  // vblank wins priority
        add(1, 0, 0, 1, 0, 0,  1, 8'hD7, 8'd0);
        add(1, 0, 0, 1, 1, 0,  0, 8'h00, 8'd0);
        add(1, 0, 0, 1, 0, 0,  0, 8'h00, 8'd0);
        add(1, 0, 0, 1, 0, 0,  0, 8'h00, 8'd0);
        add(1, 0, 0, 1, 0, 0,  1, 8'hCF, 8'd0);  // 17 second request: mid
        add(1, 0, 0, 1, 1, 0,  0, 8'h00, 8'd0);
        add(1, 0, 0, 1, 0, 0,  0, 8'h00, 8'd0);
        add(1, 0, 0, 1, 0, 0,  0, 8'h00, 8'd0);
        add(1, 0, 0, 1, 1, 0,  0, 8'h00, 8'd0);  // spurious ack, nothing pending
        add(1, 0, 1, 1, 0, 0,  0, 8'h00, 8'd0);  // 22 withdraw scenario
        add(1, 0, 1, 1, 0, 0,  1, 8'hD7, 8'd0);
        add(1, 0, 1, 0, 0, 0,  0, 8'h00, 8'd0);  // INTE dropped -> withdraw
        add(1, 0, 0, 0, 0, 0,  0, 8'h00, 8'd0);
        add(1, 0, 0, 1, 0, 0,  1, 8'hD7, 8'd0);  // re-enabled -> same vector
        add(1, 0, 0, 1, 1, 0,  0, 8'h00, 8'd0);
        add(1, 0, 0, 1, 0, 0,  0, 8'h00, 8'd0);
        add(1, 0, 0, 1, 0, 0,  0, 8'h00, 8'd0);
        add(1, 0, 0, 1, 0, 0,  0, 8'h00, 8'd0);
        add(1, 1, 0, 1, 0, 0,  0, 8'h00, 8'd0);  // 31 ack + same-source rise
        add(1, 0, 0, 1, 0, 0,  1, 8'hCF, 8'd0);
        add(1, 1, 0, 1, 1, 0,  0, 8'h00, 8'd0);  // set wins, no overrun
        add(1, 1, 0, 1, 0, 0,  0, 8'h00, 8'd0);
        add(1, 1, 0, 1, 0, 0,  0, 8'h00, 8'd0);
        add(1, 1, 0, 1, 0, 0,  1, 8'hCF, 8'd0);
        add(1, 0, 0, 1, 1, 0,  0, 8'h00, 8'd0);
        add(1, 0, 0, 1, 0, 0,  0, 8'h00, 8'd0);
        add(1, 0, 0, 1, 0, 0,  0, 8'h00, 8'd0);
        add(1, 0, 0, 1, 0, 0,  0, 8'h00, 8'd0);
        add(1, 1, 0, 1, 0, 0,  0, 8'h00, 8'd0);  // 41 overrun scenario
        add(1, 0, 0, 1, 0, 0,  1, 8'hCF, 8'd0);
        add(1, 1, 0, 1, 0, 0,  1, 8'hCF, 8'd1);  // mid overrun
        add(1, 0, 1, 1, 0, 0,  1, 8'hCF, 8'd1);  // vbl pends, sel unchanged
        add(1, 1, 0, 1, 0, 0,  1, 8'hCF, 8'd2);
        add(1, 0, 1, 1, 0, 0,  1, 8'hCF, 8'd3);  // vbl overrun
        add(1, 1, 0, 1, 0, 0,  1, 8'hCF, 8'd4);
        add(1, 0, 0, 1, 0, 0,  1, 8'hCF, 8'd4);
        add(1, 1, 1, 1, 0, 0,  1, 8'hCF, 8'd6);  // both overrun -> +2
        add(1, 0, 0, 1, 0, 1,  1, 8'hCF, 8'd0);  // clear
        add(1, 1, 0, 1, 0, 1,  1, 8'hCF, 8'd1);  // clear then add
        add(1, 0, 0, 1, 1, 0,  0, 8'h00, 8'd1);
        add(1, 0, 0, 1, 0, 0,  0, 8'h00, 8'd1);
        add(1, 0, 0, 1, 0, 0,  0, 8'h00, 8'd1);
        add(1, 0, 0, 1, 0, 0,  1, 8'hD7, 8'd1);  // vbl pended during REQ
        add(1, 0, 0, 1, 1, 0,  0, 8'h00, 8'd1);
        add(1, 0, 0, 1, 0, 0,  0, 8'h00, 8'd1);

        for (int i = 0; i < tbl.size(); i++) begin
            drive(tbl[i].rst_n, tbl[i].mid, tbl[i].vbl, tbl[i].en, tbl[i].ack, tbl[i].clr);
            check($sformatf("row%0d req", i), 32'(int_req), 32'(tbl[i].req));
            check($sformatf("row%0d vec", i), 32'(int_vector), 32'(tbl[i].vec));
            check($sformatf("row%0d ovr", i), 32'(overrun_count), 32'(tbl[i].ovr));
        end

        // 800-cycle mid-screen level: exactly one request.
        drive(0, 0, 0, 1, 0, 0);
        drive(1, 0, 0, 1, 0, 0);
        drive(1, 1, 0, 1, 0, 0);
        check("long req_after_1", 32'(int_req), 32'd0);
        drive(1, 1, 0, 1, 0, 0);
        check("long req_after_2", 32'(int_req), 32'd1);
        check("long vec", 32'(int_vector), 32'hCF);
        drive(1, 1, 0, 1, 1, 0);
        check("long ack req", 32'(int_req), 32'd0);
        check("long ack vec", 32'(int_vector), 32'h00);
        req_seen = 0;
        for (int i = 3; i < 800; i++) begin
            drive(1, 1, 0, 1, 0, 0);
            if (int_req) req_seen++;
        end
        check("long no_second_req", 32'(req_seen), 32'd0);
        drive(1, 0, 0, 1, 0, 0);

        // Overrun saturation: 301 disabled mid events -> 1 pending + 300 overruns.
        drive(0, 0, 0, 0, 0, 0);
        for (int i = 0; i < 301; i++) begin
            drive(1, 1, 0, 0, 0, 0);
            drive(1, 0, 0, 0, 0, 0);
        end
        check("sat count", 32'(overrun_count), 32'd255);
        drive(1, 0, 0, 0, 0, 1);
        check("sat clear", 32'(overrun_count), 32'd0);

        // HOLD_PENDING=1 vs 0 with three disabled mid events.
        drive(0, 0, 0, 0, 0, 0);
        for (int i = 0; i < 3; i++) begin
            drive(1, 1, 0, 0, 0, 0);
            drive(1, 0, 0, 0, 0, 0);
        end
        check("hold ovr", 32'(overrun_count), 32'd2);
        check("nohold ovr", 32'(np_overrun), 32'd0);
        drive(1, 0, 0, 1, 0, 0);
        drive(1, 0, 0, 1, 0, 0);
        check("hold req", 32'(int_req), 32'd1);
        check("hold vec", 32'(int_vector), 32'hCF);
        check("nohold req", 32'(np_req), 32'd0);
        check("nohold vec", 32'(np_vector), 32'h00);

        // Reset while a request is up and an overrun has been counted.
        drive(0, 0, 0, 1, 0, 0);
        drive(1, 1, 0, 1, 0, 0);
        drive(1, 0, 0, 1, 0, 0);
        drive(1, 1, 0, 1, 0, 0);
        check("rst pre req", 32'(int_req), 32'd1);
        check("rst pre ovr", 32'(overrun_count), 32'd1);
        drive(0, 0, 0, 1, 0, 0);
        check("rst req", 32'(int_req), 32'd0);
        check("rst vec", 32'(int_vector), 32'h00);
        check("rst ovr", 32'(overrun_count), 32'd0);
        req_seen = 0;
        for (int i = 0; i < 6; i++) begin
            drive(1, 0, 0, 1, 0, 0);
            if (int_req) req_seen++;
        end
        check("rst no_req", 32'(req_seen), 32'd0);
        drive(1, 1, 0, 1, 0, 0);
        drive(1, 1, 0, 1, 0, 0);
        check("rst new req", 32'(int_req), 32'd1);
        check("rst new vec", 32'(int_vector), 32'hCF);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
